// File: rtl/liang_pkg.sv
// Core-wide shared types: the decoded micro-op record, queue sizing defaults and
// flag+index circular pointer helpers reused by the uop queue, ROB and LSQ.
package liang_pkg;

  localparam int UOPQ_DEPTH = 8;

  typedef enum logic [2:0] {
    UOP_ALU    = 3'd0,
    UOP_BRANCH = 3'd1,
    UOP_LOAD   = 3'd2,
    UOP_STORE  = 3'd3,
    UOP_SYSTEM = 3'd4
  } uop_class_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    uop_class_e  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } uop_info_t;

  // Pointers of any queue travel through the helpers zero-extended to this width;
  // bit ptr_w is the wrap flag, bits below it are the index.
  localparam int PTR_MAX_W = 16;
  typedef logic [PTR_MAX_W:0] ptr_raw_t;

  function automatic ptr_raw_t ptr_mask(input int unsigned ptr_w);
    ptr_raw_t one_v;
    one_v = ptr_raw_t'(1);
    return (one_v << (ptr_w + 32'd1)) - one_v;
  endfunction

  // With a power-of-two depth, a plain increment of {flag,idx} wraps idx and toggles flag.
  function automatic ptr_raw_t ptr_inc(input ptr_raw_t ptr, input int unsigned ptr_w);
    return (ptr + ptr_raw_t'(1)) & ptr_mask(ptr_w);
  endfunction

  // Equal to {tail.flag^head.flag, tail.idx} - {1'b0, head.idx} modulo 2^(ptr_w+1).
  function automatic ptr_raw_t ptr_count(input ptr_raw_t head, input ptr_raw_t tail,
                                         input int unsigned ptr_w);
    return (tail - head) & ptr_mask(ptr_w);
  endfunction

endpackage

// File: rtl/circ_ptr.sv
// Flag+index circular pointer register: load (priority) or wrap-aware increment.
module circ_ptr
  import liang_pkg::*;
#(
  parameter int PTR_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_inc,
  input  logic           i_set,
  input  logic [PTR_W:0] i_set_ptr,
  output logic [PTR_W:0] o_ptr
);

  logic [PTR_W:0] r_ptr;
  logic [PTR_W:0] w_ptr_nxt;

  // Next pointer: a load wins over an increment
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_set) begin
      w_ptr_nxt = i_set_ptr;
    end else if (i_inc) begin
      w_ptr_nxt = (PTR_W + 1)'(ptr_inc(ptr_raw_t'(r_ptr), PTR_W));
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/uop_queue.sv
// Decode-to-issue micro-op FIFO with flag+index pointers and one-cycle redirect flush.
module uop_queue
  import liang_pkg::*;
#(
  parameter  int DEPTH = UOPQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic           enq_valid_i,
  output logic           enq_ready_o,
  input  uop_info_t      enq_uop_i,
  output logic           deq_valid_o,
  input  logic           deq_ready_i,
  output uop_info_t      deq_uop_o,
  output logic [PTR_W:0] count_o,
  output logic           full_o,
  output logic           empty_o
);

  typedef struct packed {
    logic             flag;
    logic [PTR_W-1:0] idx;
  } ptr_t;

  ptr_t           w_head;
  ptr_t           w_tail;
  uop_info_t      r_mem [DEPTH];
  logic           w_empty;
  logic           w_full;
  logic           w_enq_fire;
  logic           w_deq_fire;
  logic [PTR_W:0] w_count;

  // Flush snaps head onto tail, emptying the queue without touching storage.
  circ_ptr #(.PTR_W(PTR_W)) u_head (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_deq_fire),
    .i_set     (flush_i),
    .i_set_ptr (w_tail),
    .o_ptr     (w_head)
  );

  circ_ptr #(.PTR_W(PTR_W)) u_tail (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_enq_fire),
    .i_set     (1'b0),
    .i_set_ptr (w_tail),
    .o_ptr     (w_tail)
  );

  // Occupancy, handshakes and fire strobes; flush blocks both sides
  always_comb begin
    w_empty     = (w_head == w_tail);
    w_full      = (w_head.idx == w_tail.idx) && (w_head.flag != w_tail.flag);
    w_count     = (PTR_W + 1)'(ptr_count(ptr_raw_t'(w_head), ptr_raw_t'(w_tail), PTR_W));
    enq_ready_o = !w_full && !flush_i;
    deq_valid_o = !w_empty && !flush_i;
    w_enq_fire  = enq_valid_i && enq_ready_o;
    w_deq_fire  = deq_valid_o && deq_ready_i;
    count_o     = w_count;
    full_o      = w_full;
    empty_o     = w_empty;
  end

  // Entry storage, written at the tail on enqueue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enq_fire) begin
      r_mem[w_tail.idx] <= enq_uop_i;
    end else begin
      r_mem <= r_mem;
    end
  end

  assign deq_uop_o = r_mem[w_head.idx];

endmodule

// File: tb/tb_uop_queue.sv
// Scoreboard bench for uop_queue: a reference queue predicts handshakes, status and head data.
module tb_uop_queue;
  import liang_pkg::*;

  localparam int DEPTH = UOPQ_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          enq_valid_i;
  logic          enq_ready_o;
  uop_info_t     enq_uop_i;
  logic          deq_valid_o;
  logic          deq_ready_i;
  uop_info_t     deq_uop_o;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          empty_o;

  int        n_cmp = 0;
  int        n_bad = 0;
  uop_info_t sb[$];
  logic      hold_pend = 1'b0;
  uop_info_t hold_uop;

  uop_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_o),
    .enq_uop_i   (enq_uop_i),
    .deq_valid_o (deq_valid_o),
    .deq_ready_i (deq_ready_i),
    .deq_uop_o   (deq_uop_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  always #5 clk = ~clk;

  function automatic uop_info_t mk(input logic [31:0] pc);
    uop_info_t u;
    u.pc   = pc;
    u.inst = pc ^ 32'h0050_0093;
    u.cls  = pc[2] ? UOP_LOAD : UOP_ALU;
    u.rd   = pc[6:2];
    u.rs1  = pc[11:7];
    u.rs2  = ~pc[6:2];
    u.imm  = ~pc;
    return u;
  endfunction

  // One clock: drive inputs, check against the reference queue mid-cycle, update it after the edge.
  task automatic cycle(input string tag, input logic ev, input uop_info_t u,
                       input logic dr, input logic fl);
    int        exp_cnt;
    logic      exp_ready;
    logic      exp_valid;
    logic      enq_f;
    logic      deq_f;
    uop_info_t exp_u;
    if (hold_pend && (!ev || u !== hold_uop))
      $error("bench producer dropped a held uop in %s", tag);
    enq_valid_i = ev;
    enq_uop_i   = u;
    deq_ready_i = dr;
    flush_i     = fl;
    @(negedge clk);
    exp_cnt   = sb.size();
    exp_ready = (exp_cnt != DEPTH) && !fl;
    exp_valid = (exp_cnt != 0) && !fl;
    n_cmp += 5;
    if (enq_ready_o !== exp_ready) begin
      n_bad++; $display("FAIL %s enq_ready: got %b want %b", tag, enq_ready_o, exp_ready);
    end
    if (deq_valid_o !== exp_valid) begin
      n_bad++; $display("FAIL %s deq_valid: got %b want %b", tag, deq_valid_o, exp_valid);
    end
    if (count_o !== CW'(exp_cnt)) begin
      n_bad++; $display("FAIL %s count: got %0d want %0d", tag, count_o, exp_cnt);
    end
    if (full_o !== (exp_cnt == DEPTH)) begin
      n_bad++; $display("FAIL %s full: got %b want %b", tag, full_o, exp_cnt == DEPTH);
    end
    if (empty_o !== (exp_cnt == 0)) begin
      n_bad++; $display("FAIL %s empty: got %b want %b", tag, empty_o, exp_cnt == 0);
    end
    enq_f = ev && exp_ready;
    deq_f = dr && exp_valid;
    if (deq_f) begin
      exp_u = sb.pop_front();
      n_cmp++;
      if (deq_uop_o !== exp_u) begin
        n_bad++; $display("FAIL %s deq_uop: got pc %h want pc %h", tag, deq_uop_o.pc, exp_u.pc);
      end
    end else if (exp_valid) begin
      n_cmp++;
      if (deq_uop_o !== sb[0]) begin
        n_bad++; $display("FAIL %s head_hold: got pc %h want pc %h", tag, deq_uop_o.pc, sb[0].pc);
      end
    end
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else if (enq_f) sb.push_back(u);
    hold_pend = ev && !exp_ready;
    hold_uop  = u;
  endtask

  task automatic idle_inputs();
    enq_valid_i = 1'b0;
    enq_uop_i   = '0;
    deq_ready_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 6;
    if (enq_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset enq_ready: got %b want 1", enq_ready_o); end
    if (deq_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset deq_valid: got %b want 0", deq_valid_o); end
    if (count_o !== CW'(0))   begin n_bad++; $display("FAIL reset count: got %0d want 0", count_o); end
    if (full_o !== 1'b0)      begin n_bad++; $display("FAIL reset full: got %b want 0", full_o); end
    if (empty_o !== 1'b1)     begin n_bad++; $display("FAIL reset empty: got %b want 1", empty_o); end
    if (deq_uop_o !== '0)     begin n_bad++; $display("FAIL reset deq_uop: got pc %h want 0", deq_uop_o.pc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++)
      cycle("fill", 1'b1, mk(32'h8000_0000 + 32'(4 * i)), 1'b0, 1'b0);
    n_cmp += 2;
    if (full_o !== 1'b1)          begin n_bad++; $display("FAIL fill full: got %b want 1", full_o); end
    if (count_o !== CW'(DEPTH))   begin n_bad++; $display("FAIL fill count: got %0d want %0d", count_o, DEPTH); end
    for (int i = 0; i < 2; i++)
      cycle("fill_9th_held", 1'b1, mk(32'h8000_0020), 1'b0, 1'b0);
  endtask

  task automatic test_full_enq_deq();
    cycle("full_deq_enq", 1'b1, mk(32'h8000_0020), 1'b1, 1'b0);
    n_cmp++;
    if (count_o !== CW'(DEPTH - 1)) begin
      n_bad++; $display("FAIL full_deq_enq count: got %0d want %0d", count_o, DEPTH - 1);
    end
    cycle("full_retry", 1'b1, mk(32'h8000_0020), 1'b0, 1'b0);
    n_cmp++;
    if (count_o !== CW'(DEPTH)) begin
      n_bad++; $display("FAIL full_retry count: got %0d want %0d", count_o, DEPTH);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 3 == 0) begin
        cycle("drain_stall", 1'b0, '0, 1'b0, 1'b0);
        cycle("drain_stall", 1'b0, '0, 1'b0, 1'b0);
      end
      cycle("drain", 1'b0, '0, 1'b1, 1'b0);
    end
    n_cmp++;
    if (empty_o !== 1'b1) begin n_bad++; $display("FAIL drain empty: got %b want 1", empty_o); end
    cycle("drain_empty_ready", 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      cycle("b2b_prefill", 1'b1, mk(32'h9000_0000 + 32'(4 * i)), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      cycle("b2b", 1'b1, mk(32'h9000_1000 + 32'(4 * i)), 1'b1, 1'b0);
    n_cmp++;
    if (count_o !== CW'(3)) begin n_bad++; $display("FAIL b2b count: got %0d want 3", count_o); end
    for (int i = 0; i < 3; i++)
      cycle("b2b_drain", 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++)
      cycle("flush_prefill", 1'b1, mk(32'hA000_0000 + 32'(4 * i)), 1'b0, 1'b0);
    cycle("flush", 1'b1, mk(32'hA000_0100), 1'b1, 1'b1);
    n_cmp += 2;
    if (count_o !== CW'(0)) begin n_bad++; $display("FAIL flush count: got %0d want 0", count_o); end
    if (empty_o !== 1'b1)   begin n_bad++; $display("FAIL flush empty: got %b want 1", empty_o); end
    cycle("flush_push", 1'b1, mk(32'hA000_0100), 1'b0, 1'b0);
    cycle("flush_pop", 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      cycle("rstmid_fill", 1'b1, mk(32'hB000_0000 + 32'(4 * i)), 1'b0, 1'b0);
    enq_valid_i = 1'b1;
    enq_uop_i   = mk(32'hB000_0040);
    deq_ready_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (enq_ready_o !== 1'b1) begin n_bad++; $display("FAIL rstmid enq_ready: got %b want 1", enq_ready_o); end
    if (deq_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid deq_valid: got %b want 0", deq_valid_o); end
    if (count_o !== CW'(0))   begin n_bad++; $display("FAIL rstmid count: got %0d want 0", count_o); end
    if (empty_o !== 1'b1)     begin n_bad++; $display("FAIL rstmid empty: got %b want 1", empty_o); end
    if (full_o !== 1'b0)      begin n_bad++; $display("FAIL rstmid full: got %b want 0", full_o); end
    if (deq_uop_o !== '0)     begin n_bad++; $display("FAIL rstmid deq_uop: got pc %h want 0", deq_uop_o.pc); end
    sb.delete();
    hold_pend = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("rstmid_push", 1'b1, mk(32'hB000_0080), 1'b0, 1'b0);
    cycle("rstmid_pop", 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_enq_deq();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL leftover: got %0d entries want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
